// File: rtl/noc_types.sv
// Shared NoC framing definitions: serial sender FSM states and header field layout,
// also consumed by the receiver-side decoder.
package noc_types;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } noc_tx_state_e;

  // Header: destination node in the top bits, pad-bit count in the bottom bits.
  localparam int unsigned HDR_DEST_BITS = 4;
  localparam int unsigned HDR_PAD_BITS  = 4;
  localparam int unsigned HDR_PAD_LSB   = 0;

  function automatic int unsigned payload_flits(input int unsigned packet_bits,
                                                input int unsigned flit_bits);
    return (packet_bits + flit_bits - 1) / flit_bits;
  endfunction

endpackage

// File: rtl/node_port.sv
// Valid/ready NoC flit link; the injecting side uses modport up.
interface node_port #(
  parameter int unsigned FLIT_BITS = 8
);
  logic [FLIT_BITS-1:0] flit;
  logic                 valid;
  logic                 ready;

  modport up   (output flit, output valid, input ready);
  modport down (input flit, input valid, output ready);
endinterface

// File: rtl/noc_serial_sender.sv
// Generic packet serializer: one header flit then the payload LSB-first, held
// stable under back-pressure; a new packet may be loaded on the last-flit transfer.
module noc_serial_sender
  import noc_types::*;
#(
  parameter int unsigned PACKET_BITS = 32,
  parameter int unsigned FLIT_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   start,
  input  logic [FLIT_BITS-1:0]   header,
  input  logic [PACKET_BITS-1:0] payload,
  input  logic                   ready,
  output logic [FLIT_BITS-1:0]   flit,
  output logic                   valid,
  output noc_tx_state_e          state,
  output noc_tx_state_e          state_nxt_c,
  output logic                   sent_c
);

  localparam int unsigned N   = payload_flits(PACKET_BITS, FLIT_BITS);
  localparam int unsigned SHW = N * FLIT_BITS;
  localparam int unsigned CW  = $clog2(N + 1);

  noc_tx_state_e        state_q;
  logic [FLIT_BITS-1:0] flit_q, flit_d;
  logic                 valid_q, valid_d;
  logic [SHW-1:0]       shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 xfer;
  logic                 load;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt_c;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a load (from IDLE or on the last flit) overrides everything.
  always_comb begin
    state_nxt_c = state_q;
    flit_d      = flit_q;
    valid_d     = valid_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sent_c      = 1'b0;
    load        = 1'b0;
    xfer        = valid_q & ready;
    unique case (state_q)
      ST_IDLE: load = start;
      ST_HEAD: begin
        if (xfer) begin
          state_nxt_c = ST_BODY;
          flit_d      = shift_q[FLIT_BITS-1:0];
          shift_d     = shift_q >> FLIT_BITS;
        end
      end
      ST_BODY: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            sent_c      = 1'b1;
            load        = start;
            state_nxt_c = ST_IDLE;
            valid_d     = 1'b0;
            flit_d      = '0;
          end else begin
            flit_d  = shift_q[FLIT_BITS-1:0];
            shift_d = shift_q >> FLIT_BITS;
          end
        end
      end
      default: state_nxt_c = ST_IDLE;
    endcase
    if (load) begin
      state_nxt_c = ST_HEAD;
      flit_d      = header;
      valid_d     = 1'b1;
      shift_d     = SHW'(payload);
      cnt_d       = '0;
    end
  end

  assign flit  = flit_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: rtl/el2_exu_div_sender.sv
// Sends divider results onto the NoC as header + payload flits.
// Optional one-entry holding buffer enabled by NOC_DIV_SENDER_SKID_EN.
module el2_exu_div_sender
  import noc_types::*;
#(
  parameter int unsigned PACKET_BITS = 32,
  parameter int unsigned FLIT_BITS   = 8,
  parameter logic [3:0]  DEST_ID     = 4'h0
) (
  input  logic                   clk_noc,
  input  logic                   rst_l,
  node_port.up                   up,
  input  logic                   finish,
  input  logic [PACKET_BITS-1:0] result,
  input  logic                   noc_sr_flush,
  output logic                   div_ready,
  output logic                   busy,
  output logic                   sent
);

  localparam int unsigned N   = payload_flits(PACKET_BITS, FLIT_BITS);
  localparam int unsigned PAD = N * FLIT_BITS - PACKET_BITS;

  logic [FLIT_BITS-1:0]   header;
  logic [FLIT_BITS-1:0]   flit;
  logic                   valid;
  logic                   start;
  logic [PACKET_BITS-1:0] payload;
  logic                   accept;
  logic                   sent_c;
  logic                   div_ready_d;
  logic                   busy_d;
  noc_tx_state_e          state;
  noc_tx_state_e          state_nxt_c;

  always_comb begin
    header = '0;
    header[FLIT_BITS-1 -: HDR_DEST_BITS]    = DEST_ID;
    header[HDR_PAD_LSB +: HDR_PAD_BITS]     = HDR_PAD_BITS'(PAD);
  end

  // A flush in the same cycle wins over finish.
  assign accept = finish & div_ready & ~noc_sr_flush;

`ifdef NOC_DIV_SENDER_SKID_EN
  logic                   buf_full_q, buf_full_d;
  logic [PACKET_BITS-1:0] buf_data_q;
  logic                   idle;

  assign idle    = (state == ST_IDLE);
  assign start   = idle ? accept : ((buf_full_q & ~noc_sr_flush) | accept);
  assign payload = buf_full_q ? buf_data_q : result;

  // Buffer fills only when the serializer cannot take the result directly.
  always_comb begin
    buf_full_d = buf_full_q;
    if (noc_sr_flush) begin
      buf_full_d = 1'b0;
    end else if (buf_full_q && sent_c) begin
      buf_full_d = 1'b0;
    end else if (accept && !idle && !sent_c) begin
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (!rst_l) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      if (accept && !idle && !sent_c) begin
        buf_data_q <= result;
      end
    end
  end

  assign div_ready_d = ~buf_full_d;
  assign busy_d      = (state_nxt_c != ST_IDLE) | buf_full_d;
`else
  assign start       = accept & (state == ST_IDLE);
  assign payload     = result;
  assign div_ready_d = (state_nxt_c == ST_IDLE);
  assign busy_d      = (state_nxt_c != ST_IDLE);
`endif

  always_ff @(posedge clk_noc) begin
    if (!rst_l) begin
      div_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      div_ready <= div_ready_d;
      busy      <= busy_d;
    end
  end

  noc_serial_sender #(
    .PACKET_BITS (PACKET_BITS),
    .FLIT_BITS   (FLIT_BITS)
  ) u_ser (
    .clk         (clk_noc),
    .rst_l       (rst_l),
    .start       (start),
    .header      (header),
    .payload     (payload),
    .ready       (up.ready),
    .flit        (flit),
    .valid       (valid),
    .state       (state),
    .state_nxt_c (state_nxt_c),
    .sent_c      (sent_c)
  );

  assign up.flit  = flit;
  assign up.valid = valid;
  assign sent     = sent_c;

endmodule

// File: tb/tb_el2_exu_div_sender.sv
// Scoreboard bench for el2_exu_div_sender (8-bit and 12-bit flit instances).
module tb_el2_exu_div_sender;

  typedef struct packed {
    logic [15:0] flit;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        finish8 = 1'b0;
  logic        finish12 = 1'b0;
  logic [31:0] result = '0;
  logic        flush = 1'b0;
  logic        ready = 1'b1;
  logic        mon_en = 1'b1;
  logic        div_ready8, busy8, sent8;
  logic        div_ready12, busy12, sent12;
  int          checks = 0;
  int          fails = 0;
  exp_t        q8[$];
  exp_t        q12[$];

`ifdef NOC_DIV_SENDER_SKID_EN
  localparam logic DR_BUSY = 1'b1;
`else
  localparam logic DR_BUSY = 1'b0;
`endif

  node_port #(.FLIT_BITS(8))  p8();
  node_port #(.FLIT_BITS(12)) p12();
  assign p8.ready  = ready;
  assign p12.ready = ready;

  el2_exu_div_sender #(.PACKET_BITS(32), .FLIT_BITS(8), .DEST_ID(4'h0)) dut8 (
    .clk_noc(clk), .rst_l(rst_l), .up(p8), .finish(finish8), .result(result),
    .noc_sr_flush(flush), .div_ready(div_ready8), .busy(busy8), .sent(sent8));

  el2_exu_div_sender #(.PACKET_BITS(32), .FLIT_BITS(12), .DEST_ID(4'h0)) dut12 (
    .clk_noc(clk), .rst_l(rst_l), .up(p12), .finish(finish12), .result(result),
    .noc_sr_flush(flush), .div_ready(div_ready12), .busy(busy12), .sent(sent12));

  always #5 clk = ~clk;

  // Reference framing: header (DEST 0, pad count), then LSB-first chunks.
  task automatic push_pkt(input int unsigned fb, input logic [31:0] r);
    int unsigned n = (32 + fb - 1) / fb;
    int unsigned pad = n * fb - 32;
    logic [63:0] ext = {32'h0, r};
    logic [63:0] chunk;
    exp_t e;
    e.flit = 16'(pad);
    e.last = 1'b0;
    if (fb == 8) q8.push_back(e); else q12.push_back(e);
    for (int i = 0; i < int'(n); i++) begin
      chunk  = (ext >> (i * int'(fb))) & ((64'd1 << fb) - 64'd1);
      e.flit = 16'(chunk);
      e.last = (i == int'(n) - 1);
      if (fb == 8) q8.push_back(e); else q12.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_l && mon_en) begin
      checks++;
      if (p8.valid === 1'b1 && p8.ready === 1'b1) begin
        if (q8.size() == 0) begin
          fails++;
          $display("FAIL flit8_unexpected: got %h, queue empty", p8.flit);
        end else begin
          e = q8.pop_front();
          if (p8.flit !== e.flit[7:0] || sent8 !== e.last) begin
            fails++;
            $display("FAIL flit8: got flit %h sent %b, expected flit %h sent %b",
                     p8.flit, sent8, e.flit[7:0], e.last);
          end
        end
      end else if (sent8 !== 1'b0) begin
        fails++;
        $display("FAIL sent8_idle: got %b expected 0", sent8);
      end
    end
  end

  always @(negedge clk) begin : mon12
    exp_t e;
    if (rst_l && mon_en && p12.valid === 1'b1 && p12.ready === 1'b1) begin
      checks++;
      if (q12.size() == 0) begin
        fails++;
        $display("FAIL flit12_unexpected: got %h, queue empty", p12.flit);
      end else begin
        e = q12.pop_front();
        if (p12.flit !== e.flit[11:0] || sent12 !== e.last) begin
          fails++;
          $display("FAIL flit12: got flit %h sent %b, expected flit %h sent %b",
                   p12.flit, sent12, e.flit[11:0], e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b0 || p8.flit !== 8'h00 || sent8 !== 1'b0 ||
        busy8 !== 1'b0 || div_ready8 !== 1'b1) begin
      fails++;
      $display("FAIL reset: got valid %b flit %h sent %b busy %b div_ready %b, expected 0 00 0 0 1",
               p8.valid, p8.flit, sent8, busy8, div_ready8);
    end
    @(posedge clk); #1;
    rst_l = 1'b1;
  endtask

  task automatic test_basic();
    result = 32'hDEADBEEF;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (p8.valid !== 1'b1 || busy8 !== 1'b1 || div_ready8 !== DR_BUSY) begin
        fails++;
        $display("FAIL basic_cycle%0d: got valid %b busy %b div_ready %b, expected 1 1 %b",
                 c, p8.valid, busy8, div_ready8, DR_BUSY);
      end
    end
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b0 || busy8 !== 1'b0 || div_ready8 !== 1'b1) begin
      fails++;
      $display("FAIL basic_end: got valid %b busy %b div_ready %b, expected 0 0 1",
               p8.valid, busy8, div_ready8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] held = '0;
    result = 32'hCAFEF00D;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      checks++;
      if (p8.valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_valid_cycle%0d: got %b expected 1", c, p8.valid);
      end
      if (c == 3) held = p8.flit;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (p8.flit !== held) begin
          fails++;
          $display("FAIL bp_stable_cycle%0d: got %h expected %h", c, p8.flit, held);
        end
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_length: valid got %b after cycle 8, expected 0", p8.valid);
    end
    @(posedge clk); #1;
  endtask

`ifdef NOC_DIV_SENDER_SKID_EN
  task automatic test_skid();
    result = 32'hDEADBEEF;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) begin
        finish8 = 1'b1; result = 32'h1; push_pkt(8, result);
      end else if (c == 3) begin
        finish8 = 1'b1; result = 32'h3;
      end else begin
        finish8 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (p8.valid !== (c <= 10) || busy8 !== (c <= 10)) begin
        fails++;
        $display("FAIL skid_cycle%0d: got valid %b busy %b, expected %b %b",
                 c, p8.valid, busy8, c <= 10, c <= 10);
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (div_ready8 !== (c == 2)) begin
          fails++;
          $display("FAIL skid_div_ready_cycle%0d: got %b expected %b", c, div_ready8, c == 2);
        end
      end
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_blocked();
    result = 32'h0BADF00D;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      finish8 = (c == 2);
      if (c == 2) result = 32'h55AA55AA;
      @(negedge clk);
      checks++;
      if (p8.valid !== (c <= 5) || busy8 !== (c <= 5)) begin
        fails++;
        $display("FAIL blocked_cycle%0d: got valid %b busy %b, expected %b %b",
                 c, p8.valid, busy8, c <= 5, c <= 5);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_flush();
    result = 32'h00000077;
    finish8 = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    finish8 = 1'b0;
    flush = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (p8.valid !== 1'b0 || busy8 !== 1'b0) begin
        fails++;
        $display("FAIL flush_same_cycle%0d: got valid %b busy %b, expected 0 0", c, p8.valid, busy8);
      end
      @(posedge clk); #1;
    end
    result = 32'hA5A5A5A5;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      finish8 = (c == 2);
      flush = (c == 3);
      if (c == 2) result = 32'h2;
      @(negedge clk);
      checks++;
      if (p8.valid !== (c <= 5) || busy8 !== (c <= 5)) begin
        fails++;
        $display("FAIL flush_mid_cycle%0d: got valid %b busy %b, expected %b %b",
                 c, p8.valid, busy8, c <= 5, c <= 5);
      end
      @(posedge clk); #1;
    end
    finish8 = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    result = 32'h13579BDF;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    while (div_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      if (waited > 20) break;
      waited++;
      @(posedge clk); #1;
    end
    checks++;
    if (waited > 20) begin
      fails++;
      $display("FAIL b2b_timeout: div_ready %b busy %b after %0d cycles", div_ready8, busy8, waited);
    end
    result = 32'h2468ACE0;
    finish8 = 1'b1;
    push_pkt(8, result);
    @(posedge clk); #1;
    finish8 = 1'b0;
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b1 || p8.flit !== 8'h00) begin
      fails++;
      $display("FAIL b2b_header: got valid %b flit %h, expected 1 00", p8.valid, p8.flit);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_flit12();
    result = 32'h12345678;
    finish12 = 1'b1;
    push_pkt(12, result);
    @(posedge clk); #1;
    finish12 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (p12.valid !== (c <= 4) || busy12 !== (c <= 4)) begin
        fails++;
        $display("FAIL flit12_cycle%0d: got valid %b busy %b, expected %b %b",
                 c, p12.valid, busy12, c <= 4, c <= 4);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    result = 32'hFFFFFFFF;
    finish8 = 1'b1;
    @(posedge clk); #1;
    finish8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b0;
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_before: valid got %b expected 1", p8.valid);
    end
    @(negedge clk);
    checks++;
    if (p8.valid !== 1'b0 || div_ready8 !== 1'b1 || busy8 !== 1'b0 ||
        p8.flit !== 8'h00 || sent8 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got valid %b div_ready %b busy %b flit %h sent %b, expected 0 1 0 00 0",
               p8.valid, div_ready8, busy8, p8.flit, sent8);
    end
    @(posedge clk); #1;
    rst_l = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
`ifdef NOC_DIV_SENDER_SKID_EN
    test_skid();
`else
    test_blocked();
`endif
    test_flush();
    test_back_to_back();
    test_flit12();
    test_reset_mid();
    checks++;
    if (q8.size() != 0 || q12.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d / %0d flits outstanding, expected 0 / 0", q8.size(), q12.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/el2_exu_div_sender.md
EL2_EXU_DIV_SENDER -- requirements
Module: el2_exu_div_sender

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 32, payload width in bits (divider result).
REQ-002 SHALL have parameter FLIT_BITS, default 8, NoC flit width; legal range 8..PACKET_BITS.
REQ-003 SHALL have parameter DEST_ID, default 4'h0, 4-bit destination node written into the header flit.
REQ-004 SHALL have port clk_noc  input  1  NoC clock; the block uses one clock only.
REQ-005 SHALL have port rst_l  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port up  node_port.up  -  NoC injection port: drives flit[FLIT_BITS-1:0] and valid, samples ready.
REQ-007 SHALL have port finish  input  1  single-cycle strobe marking result as valid.
REQ-008 SHALL have port result  input  PACKET_BITS  divider result, sampled only when finish=1.
REQ-009 SHALL have port noc_sr_flush  input  1  discards results not yet presented on up.
REQ-010 SHALL have port div_ready  output  1  block can accept finish this cycle.
REQ-011 SHALL have port busy  output  1  a packet is in flight or buffered.
REQ-012 SHALL have port sent  output  1  one-cycle pulse when the last flit of a packet is accepted.

Function
REQ-013 SHALL frame each packet as 1 header flit followed by N=ceil(PACKET_BITS/FLIT_BITS) payload flits.
REQ-014 SHALL build the header as flit[FLIT_BITS-1 -: 4]=DEST_ID, flit[3:0]=PAD, remaining bits zero, PAD=N*FLIT_BITS-PACKET_BITS.
REQ-015 SHALL send the payload LSB first; the last payload flit carries the top bits with PAD zero bits in its MSBs.
REQ-016 SHALL implement FSM IDLE -> HEAD -> BODY -> IDLE; HEAD->BODY on header accept, BODY->IDLE (or HEAD if a result is buffered) on last-flit accept.
REQ-017 SHALL count payload flits with a counter of clog2(N+1) bits, cleared on entry to HEAD.
REQ-018 SHALL count a flit transferred only in a cycle where valid=1 and ready=1.
REQ-019 SHALL hold flit and valid stable while valid=1 and ready=0; valid is never retracted mid-packet.
REQ-020 SHALL present the header in the cycle after finish is captured in IDLE (capture-to-header latency 1 cycle).
REQ-021 SHALL, with ready held high, complete a packet in N+1 consecutive cycles and pulse sent in the cycle of the last-flit transfer.
REQ-022 SHALL drive div_ready=1 in IDLE; behaviour outside IDLE is defined under Configuration.
REQ-023 SHALL ignore finish when div_ready=0 (result dropped, no state change).
REQ-024 SHALL, on noc_sr_flush=1, drop a finish in the same cycle and clear the holding buffer; a packet whose header is already presented completes unchanged.
REQ-025 SHALL drive busy=1 whenever state!=IDLE or the holding buffer is full.

Reset
REQ-026 SHALL, with rst_l=0 at a clk_noc edge, enter IDLE, clear counter and buffer, and drive valid=0, sent=0, busy=0, div_ready=1, flit=0.
REQ-027 SHALL abandon any packet in flight on reset; NoC-side reset is coincident, so no recovery flit is sent.

Configuration
REQ-028 SHALL, with NOC_DIV_SENDER_SKID_EN defined, include a one-entry holding buffer: div_ready=1 outside IDLE while the buffer is empty; a buffered result starts its header the cycle after the current last-flit transfer.
REQ-029 SHALL, without NOC_DIV_SENDER_SKID_EN, have no buffer: div_ready=0 outside IDLE, FSM returns to IDLE after each packet.

Structure
REQ-030 SHALL place the FSM state enum and header field offsets (DEST 4 bits, PAD 4 bits) in noc_types for use by el2_exu_div_receiver-side decoding.
REQ-031 SHALL use one sub-module, noc_serial_sender (PACKET_BITS, FLIT_BITS generic), holding FSM, counter and shift register; el2_exu_div_sender adds buffer, flush and header constants.

Verification
REQ-032 SHALL cover: finish with result=32'hDEADBEEF, ready=1, defaults -> flits 8'h00,EF,BE,AD,DE on 5 consecutive cycles, sent on the 5th.
REQ-033 SHALL cover: FLIT_BITS=12, result=32'h12345678 -> header 12'h004, payload 12'h678,12'h345,12'h012.
REQ-034 SHALL cover: ready=0 for 3 cycles on second payload flit -> flit and valid stable, total packet 8 cycles.
REQ-035 SHALL cover: SKID_EN, second finish (32'h1) during first packet -> accepted, its header immediately follows first packet; third finish with buffer full ignored.
REQ-036 SHALL cover: finish and noc_sr_flush same cycle -> no valid, busy stays 0; flush mid-packet -> packet completes, buffered result dropped.
REQ-037 SHALL cover: rst_l=0 during BODY -> next cycle valid=0, div_ready=1, busy=0.
